// File: rtl/sipo_8bit_rx.sv
// sipo_8bit_rx: MSB-first serial-to-parallel receiver with valid/ready output and sticky overrun.
// Define SIPO_PARITY_EN for 9-bit frames ending in an even-parity bit (reported on parity_err).
module sipo_8bit_rx #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_en,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);
`ifdef SIPO_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  localparam int CW = $clog2(F + 1);
  logic [F-2:0]     shreg;
  logic [CW-1:0]    cnt;
  logic [F-1:0]     frame;
  logic [WIDTH-1:0] word;
  logic             perr, done, load;
  // frame is the full received frame including the bit arriving this cycle
  assign frame = {shreg, si};
`ifdef SIPO_PARITY_EN
  assign word = frame[F-1:1];
  assign perr = ^frame;
`else
  assign word = frame;
  assign perr = 1'b0;
`endif
  assign done = si_en && cnt == CW'(F - 1);
  assign load = done && (!po_valid || po_ready);
  assign busy = cnt != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      cnt        <= '0;
      po         <= '0;
      po_valid   <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (si_en) begin
        shreg <= frame[F-2:0];
        cnt   <= done ? '0 : cnt + CW'(1);
      end
      if (load) begin
        po         <= word;
        parity_err <= perr;
      end
      po_valid <= load || (po_valid && !po_ready);
      if (done && po_valid && !po_ready) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sipo_8bit_rx.sv
// tb_sipo_8bit_rx: directed and randomized stimulus against a queue-based reference model with a handshake scoreboard.
module tb_sipo_8bit_rx;
`ifdef SIPO_PARITY_EN
  localparam int F = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int F = 8;
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, si = 1'b0, si_en = 1'b0, po_ready = 1'b0;
  logic [7:0] po;
  logic po_valid, busy, overrun, parity_err;
  int tests = 0, fails = 0, rmode = 0;
  bit started = 1'b0;
  logic [8:0] sent[$];
  logic [8:0] dq[$];
  logic [8:0] m_po = '0, w, hw;
  logic m_held = 1'b0, m_ovr = 1'b0, m_done;
  int m_bits = 0;

  sipo_8bit_rx dut (
    .clk(clk), .rst(rst), .si(si), .si_en(si_en), .po(po), .po_valid(po_valid),
    .po_ready(po_ready), .busy(busy), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words are delivered in order; the single output slot accepts
  // a finished word if it is free or being consumed, otherwise the word is lost.
  always @(posedge clk) begin
    if (rst) begin
      m_bits = 0; m_held = 1'b0; m_ovr = 1'b0; m_po = '0;
      dq.delete(); sent.delete();
    end else begin
      m_done = 1'b0;
      if (si_en) begin
        m_bits = (m_bits + 1) % F;
        m_done = (m_bits == 0);
      end
      if (m_done) begin
        w = sent.size() != 0 ? sent.pop_front() : 9'h1ff;
        if (!m_held || po_ready) begin
          dq.push_back(w); m_po = w; m_held = 1'b1;
        end else m_ovr = 1'b1;
      end else if (m_held && po_ready) m_held = 1'b0;
    end
  end

  always begin
    @(negedge clk); #3;
    if (started) begin
      chk("po_valid", 32'(po_valid), 32'(m_held));
      chk("po", 32'(po), 32'(m_po[7:0]));
      chk("parity_err", 32'(parity_err), 32'(m_po[8]));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("busy", 32'(busy), 32'(m_bits != 0));
      if (po_valid && po_ready && !rst) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL handshake: got word %0h want no word offered", po);
        end else begin
          hw = dq.pop_front();
          chk("handshake_word", 32'(po), 32'(hw[7:0]));
        end
      end
    end
  end

  task automatic set_ready();
    po_ready = rmode == 2 ? 1'($urandom) : (rmode == 1);
  endtask

  task automatic idle(int n);
    repeat (n) begin @(negedge clk); #1; si_en = 1'b0; si = 1'($urandom); set_ready(); end
  endtask

  task automatic drive_bit(logic b, int gmin, int gmax);
    idle($urandom_range(gmax, gmin));
    @(negedge clk); #1; si = b; si_en = 1'b1; set_ready();
  endtask

  task automatic send(logic [7:0] d, logic bad, int gmin, int gmax);
    sent.push_back({bad & PAR, d});
    for (int i = 7; i >= 0; i--) drive_bit(d[i], gmin, gmax);
    if (PAR) drive_bit(^d ^ bad, gmin, gmax);
  endtask

  task automatic do_reset();
    @(negedge clk); #1; rst = 1'b1; si_en = 1'b0; po_ready = 1'b0;
    @(negedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    do_reset();
    started = 1'b1;
    chk("reset_po", 32'(po), 32'h0);
    chk("reset_valid", 32'(po_valid), 32'h0);
    rmode = 0;
    send(8'hC6, 1'b0, 0, 0); idle(1);
    chk("dir_c6_po", 32'(po), 32'hC6);
    chk("dir_c6_valid", 32'(po_valid), 32'h1);
    chk("dir_c6_busy", 32'(busy), 32'h0);
    rmode = 1; idle(1); rmode = 0; idle(1);
    chk("dir_consumed", 32'(po_valid), 32'h0);
    send(8'h3F, 1'b0, 1, 1); idle(1);
    chk("dir_3f_po", 32'(po), 32'h3F);
    chk("dir_3f_valid", 32'(po_valid), 32'h1);
    do_reset();
    send(8'hC6, 1'b0, 0, 0); send(8'h3F, 1'b0, 0, 0); idle(1);
    chk("dir_ovr_po", 32'(po), 32'hC6);
    chk("dir_ovr_flag", 32'(overrun), 32'h1);
    do_reset(); rmode = 1;
    send(8'hC6, 1'b0, 0, 0); send(8'h3F, 1'b0, 0, 0); rmode = 0; idle(1);
    chk("dir_b2b_po", 32'(po), 32'h3F);
    chk("dir_b2b_ovr", 32'(overrun), 32'h0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 0, 0);
    idle(1);
    chk("dir_partial_busy", 32'(busy), 32'h1);
    do_reset();
    chk("dir_rst_po", 32'(po), 32'h0);
    chk("dir_rst_busy", 32'(busy), 32'h0);
    chk("dir_rst_valid", 32'(po_valid), 32'h0);
    send(8'hA5, 1'b0, 0, 0); idle(1);
    chk("dir_a5_po", 32'(po), 32'hA5);
    chk("dir_a5_valid", 32'(po_valid), 32'h1);
    if (PAR) begin
      rmode = 1; idle(1); rmode = 0;
      send(8'hC6, 1'b0, 0, 0); idle(1);
      chk("par_ok", 32'(parity_err), 32'h0);
      rmode = 1; idle(1); rmode = 0;
      send(8'hC6, 1'b1, 0, 0); idle(1);
      chk("par_err_po", 32'(po), 32'hC6);
      chk("par_err_flag", 32'(parity_err), 32'h1);
    end
    rmode = 2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(49, 0) == 0) begin
        for (int i = 0; i < int'($urandom_range(7, 1)); i++) drive_bit(1'($urandom), 0, 1);
        do_reset();
      end
      send(8'($urandom), 1'($urandom), 0, $urandom_range(1, 0) == 0 ? 0 : 2);
      if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
    end
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
